// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped write-through data cache.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: FSM state enum, tag width derivation, line record, byte-merge helper.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int STRB_W    = WORD_W / 8;
    // Widest tag the record must hold; narrower tags sit zero-extended in it.
    localparam int TAG_MAX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        STORE,
        RESP
    } state_t;

    // Tag bits left above the line index and the byte offset.
    function automatic int tag_w(input int index_bits);
        return ADDR_W - index_bits - 2;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [WORD_W-1:0]    data;
    } line_t;

    // Replace the byte lanes selected by strb, keep the rest.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for data_cache: valid bits, tags and one data word per line.
// Latency: combinational read by index; writes land on the next rising clk.
// Backpressure: none, a write is taken every cycle wr_en is high.
//
// Ports:
//   clk, rst            clock, async active-high reset (clears valid bits only)
//   rd_idx / rd_line    lookup index and the line record stored there
//   wr_en               write strobe
//   wr_fill             1 = install whole line (set valid, replace tag),
//                       0 = merge bytes into existing data, tag/valid untouched
//   wr_idx, wr_tag      target line and tag (tag used only on fill)
//   wr_data, wr_strb    write data and byte lanes
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output line_t                 rd_line,
    input  logic                  wr_en,
    input  logic                  wr_fill,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_MAX_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [STRB_W-1:0]     wr_strb
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_MAX_W-1:0] tag_q  [LINES];
    logic [WORD_W-1:0]    data_q [LINES];

    // Only the valid bits need reset; tag/data are don't-care while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill) begin
                tag_q[wr_idx] <= wr_tag;
            end
            data_q[wr_idx] <= byte_merge(data_q[wr_idx], wr_data, wr_strb);
        end
    end

    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_q[rd_idx];
        rd_line.tag   = tag_q[rd_idx];
        rd_line.data  = data_q[rd_idx];
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache between CPU and memory.
// Latency: read hit -> data_ready next cycle; miss/store -> one cycle after mem_ready.
// Backpressure: one request at a time; CPU holds read/write until data_ready pulses.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   read, write, addr, wdata CPU request (write = byte strobes, nonzero = store)
//   rdata, data_ready        load word and one-cycle completion pulse
//   mem_read, mem_write      memory request (read / byte-strobed write)
//   mem_addr, mem_wdata      word-aligned memory address and store data
//   mem_rdata, mem_ready     memory response
//   hit_cnt, miss_cnt        read hit/miss counters, only with DCACHE_STATS_EN defined
module data_cache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [STRB_W-1:0] write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              data_ready,
    output logic              mem_read,
    output logic [STRB_W-1:0] mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = tag_w(INDEX_BITS);

    state_t                state;
    line_t                 line;
    logic [ADDR_W-1:0]     look_addr;
    logic [INDEX_BITS-1:0] look_idx;
    logic [TAG_MAX_W-1:0]  look_tag;
    logic                  hit;
    logic                  arr_wr_en;
    logic                  arr_fill;
    logic [WORD_W-1:0]     arr_wr_data;
    logic [STRB_W-1:0]     arr_wr_strb;
    logic                  unused_addr_bits;

    // While busy the registered mem_addr/mem_write/mem_wdata hold the captured
    // request, so they double as the request registers. In IDLE the live CPU
    // address drives the lookup so a hit can complete next cycle.
    assign look_addr = (state == IDLE) ? addr : mem_addr;
    assign look_idx  = look_addr[INDEX_BITS+1:2];
    assign look_tag  = TAG_MAX_W'(look_addr[ADDR_W-1:INDEX_BITS+2]);
    assign hit       = line.valid && (line.tag == look_tag);

    assign unused_addr_bits = ^look_addr[1:0];

    // Fill on a completed miss; on a completed store, merge only if the line
    // already holds this address (no allocate on write miss).
    always_comb begin
        arr_wr_en   = 1'b0;
        arr_fill    = 1'b0;
        arr_wr_data = mem_wdata;
        arr_wr_strb = mem_write;
        if (state == MISS && mem_ready) begin
            arr_wr_en   = 1'b1;
            arr_fill    = 1'b1;
            arr_wr_data = mem_rdata;
            arr_wr_strb = '1;
        end else if (state == STORE && mem_ready && hit) begin
            arr_wr_en   = 1'b1;
        end
    end

    dcache_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (look_idx),
        .rd_line (line),
        .wr_en   (arr_wr_en),
        .wr_fill (arr_fill),
        .wr_idx  (look_idx),
        .wr_tag  (look_tag),
        .wr_data (arr_wr_data),
        .wr_strb (arr_wr_strb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rdata      <= '0;
            data_ready <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // Store wins when read and write are both presented.
                    if (write != '0) begin
                        mem_write <= write;
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= wdata;
                        state     <= STORE;
                    end else if (read) begin
                        if (hit) begin
                            rdata      <= line.data;
                            data_ready <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_ready) begin
                        mem_read   <= 1'b0;
                        mem_addr   <= '0;
                        rdata      <= mem_rdata;
                        data_ready <= 1'b1;
                        state      <= RESP;
                    end
                end
                STORE: begin
                    if (mem_ready) begin
                        mem_write  <= '0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        data_ready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // data_ready was raised on entry; this cycle drops it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Counts reads accepted in IDLE; a read masked by a simultaneous store is a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && write == '0 && read) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: randomized traffic against a reference model.
// Latency: checks exact completion latency for hits, misses and stores.
// Backpressure: bench memory responder inserts 0-3 wait cycles per request.
`timescale 1ns/1ps
module tb_data_cache;

    localparam int INDEX_BITS = 4;
    localparam int LINES      = 2 ** INDEX_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [3:0]  write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        data_ready;
    logic        mem_read;
    logic [3:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_cache #(
        .INDEX_BITS(INDEX_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .data_ready (data_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    // Reference model: backing memory contents plus which word address each
    // line currently holds. With write-through, a cached word always equals memory.
    logic [31:0] mem_model [logic [31:0]];
    bit          cached      [LINES];
    logic [31:0] cached_addr [LINES];
    int          cur_dly  = 0;
    bit          hold_mem = 1'b0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_model.exists(a)) begin
            return mem_model[a];
        end
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: compares each request against the expected queue,
    // waits cur_dly cycles, then answers for one cycle.
    initial begin
        mem_exp_t    e;
        logic [31:0] a;
        int          n;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || (!mem_read && mem_write == 4'b0000)) continue;
            a = mem_addr;
            if (mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_req: mem_read=%b mem_write=%b addr=%h, none expected",
                         mem_read, mem_write, mem_addr);
                e.is_wr = (mem_write != 4'b0000);
                e.addr  = a;
                e.strb  = mem_write;
                e.wdata = mem_wdata;
            end else begin
                e = mem_q.pop_front();
                check("mem_req_kind", {30'b0, mem_read, (mem_write != 4'b0000)},
                      {30'b0, !e.is_wr, e.is_wr});
                check("mem_addr", mem_addr, e.addr);
                if (e.is_wr) begin
                    check("mem_write_strb", {28'b0, mem_write}, {28'b0, e.strb});
                    check("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (hold_mem) begin
                n = 0;
                while ((mem_read || mem_write != 4'b0000) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
            end else begin
                repeat (cur_dly) begin
                    @(negedge clk);
                    check("mem_addr_stable", mem_addr, a);
                end
                if (e.is_wr) begin
                    mem_model[e.addr] = merge_bytes(mem_word(e.addr), e.wdata, e.strb);
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = mem_word(e.addr);
                end
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                check("mem_req_dropped", {27'b0, mem_read, mem_write}, 32'd0);
            end
        end
    end

    // Response monitor: every data_ready pulse consumes one expected response.
    initial begin
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (data_ready) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_ready: rdata=%h, no request outstanding", rdata);
                end else begin
                    r = resp_q.pop_front();
                    if (r.is_rd) check("rdata", rdata, r.rdata);
                end
            end
        end
    end

    // Issue one request, hold it until data_ready, check completion latency.
    task automatic do_req(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input int dly);
        logic [31:0] wa;
        int          idx;
        bit          hit;
        int          lat;
        mem_exp_t    me;
        resp_exp_t   re;
        @(negedge clk);
        wa  = {a[31:2], 2'b00};
        idx = int'(wa[5:2]);
        hit = 1'b0;
        cur_dly = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        if (wr != 4'b0000) begin
            me = '{1'b1, wa, wr, wd};
            mem_q.push_back(me);
            re = '{1'b0, 32'd0};
        end else begin
            hit = cached[idx] && (cached_addr[idx] == wa);
            if (hit) begin
                exp_hits++;
            end else begin
                exp_misses++;
                me = '{1'b0, wa, 4'b0000, 32'd0};
                mem_q.push_back(me);
                cached[idx]      = 1'b1;
                cached_addr[idx] = wa;
            end
            re = '{1'b1, mem_word(wa)};
        end
        resp_q.push_back(re);
        read  = rd;
        write = wr;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        #1;
        // Request is latched; anything else on the bus while busy must be ignored.
        addr  = $urandom;
        wdata = $urandom;
        lat   = 1;
        @(negedge clk);
        while (!data_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!data_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: no data_ready within %0d cycles for addr %h", lat, wa);
        end else begin
            check("completion_latency", 32'(lat), (wr == 4'b0000 && hit) ? 32'd1 : 32'(cur_dly + 2));
        end
        read  = 1'b0;
        write = 4'b0000;
    endtask

    // Start a read miss, then reset while the fill is outstanding.
    task automatic reset_during_miss(input logic [31:0] a);
        mem_exp_t me;
        int       n;
        @(negedge clk);
        me = '{1'b0, {a[31:2], 2'b00}, 4'b0000, 32'd0};
        mem_q.push_back(me);
        hold_mem = 1'b1;
        read = 1'b1;
        addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read && n < 20);
        check("miss_issues_mem_read", {31'b0, mem_read}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_drops_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_clears_rdata", rdata, 32'd0);
        read = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_data_ready_in_rst", {31'b0, data_ready}, 32'd0);
        end
        rst      = 1'b0;
        hold_mem = 1'b0;
        for (int i = 0; i < LINES; i++) cached[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        repeat (2) begin
            @(negedge clk);
            check("no_data_ready_after_rst", {31'b0, data_ready}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rs;
        int          op;
        rst   = 1'b1;
        read  = 1'b0;
        write = 4'b0000;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < LINES; i++) begin
            cached[i]      = 1'b0;
            cached_addr[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_data_ready", {31'b0, data_ready}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {28'b0, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        rst = 1'b0;

        // Directed scenarios.
        mem_model[32'h100] = 32'hDEAD_BEEF;
        do_req(1'b1, 4'b0000, 32'h100, 32'h0, 3);             // miss, 3 wait cycles
        do_req(1'b1, 4'b0000, 32'h100, 32'h0, -1);            // hit
        do_req(1'b0, 4'b0011, 32'h100, 32'h0000_CAFE, -1);    // store, merges into line
        do_req(1'b1, 4'b0000, 32'h102, 32'h0, -1);            // hit, 0xDEADCAFE
        do_req(1'b0, 4'b1111, 32'h200, 32'h1234_5678, 0);     // store miss, no allocate
        do_req(1'b1, 4'b0000, 32'h200, 32'h0, -1);            // must fetch
        do_req(1'b1, 4'b1111, 32'h140, 32'hA5A5_5A5A, -1);    // store wins over read
        do_req(1'b1, 4'b0000, 32'h140, 32'h0, -1);
        reset_during_miss(32'h300);
        do_req(1'b1, 4'b0000, 32'h300, 32'h0, -1);            // line left invalid
        do_req(1'b1, 4'b0000, 32'h100, 32'h0, -1);            // all lines invalid after rst

        // Randomized traffic over a small, conflict-heavy address pool.
        for (int k = 0; k < 250; k++) begin
            ra = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) ra = ra | 32'h8000_0000;
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                rs = 4'($urandom_range(1, 15));
                do_req((op == 0), rs, ra, $urandom, -1);
            end else begin
                do_req(1'b1, 4'b0000, ra, $urandom, -1);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
